trakball_quad_gen: RTL and testbench
====================================

// Module: trakball_quad_gen
// PURPOSE
// - Trak-Ball emulator. Generates the quadrature signals that the LETA trackball counter
//   decodes, so the LETA gets the same inputs a physical trackball would give it.
// - A host source (PS/2 or USB bridge, or a testbench) posts signed X/Y motion deltas.
// - Each axis accumulates its pending motion and plays it out as paced Gray-code
//   quadrature steps on quad_x_a/b and quad_y_a/b.
// PARAMETERS
// - DW        8   width of the signed delta inputs
// - AW        12  width of the signed per-axis accumulators; must be greater than DW
// - STEP_DIV  16  clk cycles per quadrature step; must be at least 8
// PORTS
// - clk         in   1   system clock; all state changes on the posedge
// - rst_b       in   1   asynchronous active-low reset
// - delta_x     in   DW  signed X motion, two's complement
// - delta_y     in   DW  signed Y motion, two's complement
// - delta_valid in   1   delta_x and delta_y are presented
// - delta_ready out  1   block accepts a delta this cycle
// - ovf_clr     in   1   clears ovf
// - quad_x_a    out  1   X channel A
// - quad_x_b    out  1   X channel B
// - quad_y_a    out  1   Y channel A
// - quad_y_b    out  1   Y channel B
// - busy        out  1   at least one accumulator is nonzero
// - ovf         out  1   sticky: an accumulator saturated
// BEHAVIOUR
// - Reset (async, rst_b=0):
//   - all accumulators, phases, tick counter and ovf clear to 0
//   - all quad_* = 0; busy = 0; delta_ready = 0
// - delta_ready is a registered 1 from the first clk edge after rst_b rises; it never drops.
// - Accept: delta_valid & delta_ready at a clk edge. Both axes load in the same edge.
//   A zero delta is legal and is a no-op.
// - Tick counter:
//   - free-running 0..STEP_DIV-1 from reset, wraps to 0
//   - tick = (cnt == STEP_DIV-1); the first tick occurs on edge STEP_DIV after reset release
// - Per axis, evaluated on every edge:
//   - step = 0 if no tick or acc == 0; +1 if tick and acc > 0; -1 if tick and acc < 0
//   - step uses the registered acc value, before that edge's delta is added
//   - acc_next = sat(acc - step + (accepted ? sext(delta) : 0)), computed at AW+1 bits
//   - sat clamps to [-(2^(AW-1)-1), +(2^(AW-1)-1)]; the range is symmetric
//   - if any clamp occurs, ovf <= 1
// - Phase p (2-bit, per axis):
//   - p <= p + step (mod 4)
//   - mapping: p=0 -> A0B0, 1 -> A1B0, 2 -> A1B1, 3 -> A0B1
//   - positive motion makes A lead B; negative motion makes B lead A
//   - exactly one of A/B toggles per step, never both
// - quad_* are registered and change only on tick edges.
// - Latency: 1..STEP_DIV clk from accept to the first edge. Steady rate is one step per
//   STEP_DIV clk. A motion of n steps finishes in about n*STEP_DIV clk.
// - busy = (acc_x != 0) | (acc_y != 0); registered, so it reflects acc after each edge.
// - ovf_clr and a new saturation in the same cycle: saturation wins, ovf stays 1.
// - Reset mid-run: pending motion is discarded and quad_* go to 0 immediately. The LETA
//   sees at most one extra edge per channel, which is acceptable.
// CONFIGURATION
// - Macro TRAKBALL_RATE_SEL_EN.
// - Defined:
//   - adds input rate_sel[1:0]
//   - effective divider D = STEP_DIV >> rate_sel
//   - tick = (cnt >= D-1), after which cnt wraps to 0
//   - so a rate change mid-count takes effect within one period with no lockup
// - Undefined: no rate_sel port; D = STEP_DIV fixed.
// TESTING (STEP_DIV=16, DW=8, AW=12)
// - Reset: hold rst_b=0 for 3 clk, then release.
//   -> quad_*=0, busy=0, ovf=0; delta_ready=1 after the first edge.
// - Accept delta_x=+3, delta_y=0.
//   -> X goes (A,B)=00 -> 10 -> 11 -> 01, one step per tick, 16 clk apart.
//   -> Y static; busy drops after the third step.
// - Accept delta_y=-2.
//   -> Y goes 00 -> 01 -> 11 (B leads); acc_y ends 0.
// - Accept delta_x=+127 on 20 consecutive cycles.
//   -> acc_x clamps at 2047 and ovf=1.
//   -> pulse ovf_clr -> ovf=0 while X keeps stepping.
// - Hold acc_x=+1 and accept delta_x=-1 on a tick edge.
//   -> X steps forward once and acc_x = -1.
//   -> the next tick steps X back; acc_x = 0.
// - Drop rst_b mid-motion (acc_x=+50).
//   -> all outputs 0 asynchronously; after release no further X edges.
// - (TRAKBALL_RATE_SEL_EN) rate_sel=2 with delta_x=+4.
//   -> X steps 4 clk apart (D=4).

Source files
------------

// File: rtl/trakball_quad_gen.sv
// trakball_quad_gen: Trak-Ball emulator turning posted X/Y motion deltas into paced Gray-code quadrature for the LETA counter.
//
// Ports:
//   clk           system clock, all state changes on posedge
//   rst_b         asynchronous active-low reset
//   delta_x/y     signed DW-bit motion deltas, two's complement
//   delta_valid   deltas presented this cycle
//   delta_ready   registered 1 from the first edge after reset release
//   ovf_clr       clears the sticky overflow flag
//   rate_sel      (only with TRAKBALL_RATE_SEL_EN) step divider = STEP_DIV >> rate_sel
//   quad_x_a/b    X quadrature channels
//   quad_y_a/b    Y quadrature channels
//   busy          an accumulator is nonzero
//   ovf           sticky: an accumulator saturated
//
// Optional feature macro: TRAKBALL_RATE_SEL_EN.
module trakball_quad_gen #(
    parameter int DW       = 8,
    parameter int AW       = 12,
    parameter int STEP_DIV = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [DW-1:0] delta_x,
    input  logic [DW-1:0] delta_y,
    input  logic          delta_valid,
    output logic          delta_ready,
    input  logic          ovf_clr,
`ifdef TRAKBALL_RATE_SEL_EN
    input  logic [1:0]    rate_sel,
`endif
    output logic          quad_x_a,
    output logic          quad_x_b,
    output logic          quad_y_a,
    output logic          quad_y_b,
    output logic          busy,
    output logic          ovf
);
    localparam int CW = $clog2(STEP_DIV);
    localparam logic signed [AW:0] MAX_V = (AW+1)'((2 ** (AW - 1)) - 1);
    logic [CW-1:0] cnt;
    logic tick, rdy;
    logic signed [AW-1:0] acc [2];
    logic signed [AW-1:0] acc_nx [2];
    logic [1:0] ph [2];
    logic [1:0] ph_nx [2];
    logic [DW-1:0] dlt [2];
    logic signed [AW:0] sum [2];
    logic [1:0] up, dn, sat, qa, qb;
    assign dlt[0] = delta_x;
    assign dlt[1] = delta_y;
`ifdef TRAKBALL_RATE_SEL_EN
    logic [CW-1:0] div_m1;
    assign div_m1 = CW'((STEP_DIV >> rate_sel) - 1);
    // >= rather than == so a shortened divider never strands cnt above the wrap point
    assign tick = cnt >= div_m1;
`else
    assign tick = cnt == CW'(STEP_DIV - 1);
`endif
    // One extra bit of headroom so the clamp sees the true sum before saturating.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            up[i] = tick && !acc[i][AW-1] && acc[i] != '0;
            dn[i] = tick && acc[i][AW-1];
            sum[i] = {acc[i][AW-1], acc[i]} - (AW+1)'(up[i]) + (AW+1)'(dn[i])
                   + (delta_valid && rdy ? {{(AW+1-DW){dlt[i][DW-1]}}, dlt[i]} : '0);
            sat[i] = sum[i] > MAX_V || sum[i] < -MAX_V;
            acc_nx[i] = sum[i] > MAX_V ? AW'(MAX_V) : sum[i] < -MAX_V ? AW'(-MAX_V) : AW'(sum[i]);
            // +1 forward, +3 (i.e. -1) backward
            ph_nx[i] = ph[i] + {dn[i], up[i] | dn[i]};
        end
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt  <= '0;
            rdy  <= 1'b0;
            ovf  <= 1'b0;
            busy <= 1'b0;
            qa   <= '0;
            qb   <= '0;
            for (int i = 0; i < 2; i++) begin
                acc[i] <= '0;
                ph[i]  <= '0;
            end
        end else begin
            cnt  <= tick ? '0 : cnt + CW'(1);
            rdy  <= 1'b1;
            ovf  <= (|sat) | (ovf & ~ovf_clr);
            busy <= acc_nx[0] != '0 || acc_nx[1] != '0;
            for (int i = 0; i < 2; i++) begin
                acc[i] <= acc_nx[i];
                ph[i]  <= ph_nx[i];
                // Gray map 0:00 1:10 2:11 3:01 as {A,B}
                qa[i]  <= ^ph_nx[i];
                qb[i]  <= ph_nx[i][1];
            end
        end
    end
    assign delta_ready = rdy;
    assign quad_x_a    = qa[0];
    assign quad_x_b    = qb[0];
    assign quad_y_a    = qa[1];
    assign quad_y_b    = qb[1];
endmodule

// File: tb/tb_trakball_quad_gen.sv
// tb_trakball_quad_gen: directed and random checks of trakball_quad_gen against a step-count reference model.
module tb_trakball_quad_gen;
    localparam int SD   = 16;
    localparam int MAXA = 2047;
    logic clk = 1'b0;
    logic rst_b = 1'b1;
    logic [7:0] delta_x = '0, delta_y = '0;
    logic delta_valid = 1'b0, ovf_clr = 1'b0;
    logic delta_ready, quad_x_a, quad_x_b, quad_y_a, quad_y_b, busy, ovf;
`ifdef TRAKBALL_RATE_SEL_EN
    logic [1:0] rate_sel = 2'd0;
`endif
    int compared = 0;
    int mismatched = 0;
    // Reference: pending motion and net step position per axis, edges since release.
    int  m_acc [2];
    int  m_pos [2];
    int  m_n;
    int  m_div = SD;
    bit  m_ovf, m_rdy;

    trakball_quad_gen dut (
        .clk(clk), .rst_b(rst_b),
        .delta_x(delta_x), .delta_y(delta_y),
        .delta_valid(delta_valid), .delta_ready(delta_ready),
        .ovf_clr(ovf_clr),
`ifdef TRAKBALL_RATE_SEL_EN
        .rate_sel(rate_sel),
`endif
        .quad_x_a(quad_x_a), .quad_x_b(quad_x_b),
        .quad_y_a(quad_y_a), .quad_y_b(quad_y_b),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] quad_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("quad_x", {2'b00, quad_x_a, quad_x_b}, {2'b00, quad_of(m_pos[0])});
        chk("quad_y", {2'b00, quad_y_a, quad_y_b}, {2'b00, quad_of(m_pos[1])});
        chk("busy", {3'b000, busy}, {3'b000, m_acc[0] != 0 || m_acc[1] != 0});
        chk("ovf", {3'b000, ovf}, {3'b000, m_ovf});
        chk("delta_ready", {3'b000, delta_ready}, {3'b000, m_rdy});
    endtask

    task automatic cyc(input int dx, input int dy, input bit v, input bit clr);
        int  d [2];
        int  s, nv;
        bit  tk, sat, take;
        delta_x = 8'(dx);
        delta_y = 8'(dy);
        delta_valid = v;
        ovf_clr = clr;
        @(posedge clk);
        #1;
        if (rst_b) begin
            take = v && m_rdy;
            m_n++;
            tk = (m_n % m_div) == 0;
            d[0] = dx;
            d[1] = dy;
            sat = 1'b0;
            for (int i = 0; i < 2; i++) begin
                s = (tk && m_acc[i] != 0) ? (m_acc[i] > 0 ? 1 : -1) : 0;
                m_pos[i] += s;
                nv = m_acc[i] - s + (take ? d[i] : 0);
                if (nv > MAXA) begin nv = MAXA; sat = 1'b1; end
                if (nv < -MAXA) begin nv = -MAXA; sat = 1'b1; end
                m_acc[i] = nv;
            end
            m_ovf = sat ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_rdy = 1'b1;
        end
        check_all();
        delta_valid = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 1'b0, 1'b0);
    endtask

    // Asserted between edges so the asynchronous clear is observed without a clock.
    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        m_acc = '{0, 0};
        m_pos = '{0, 0};
        m_ovf = 1'b0;
        m_rdy = 1'b0;
        m_n = 0;
        check_all();
        idle(3);
        rst_b = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        idle(3);
        // +3 on X: three forward steps, A leads B
        cyc(3, 0, 1'b1, 1'b0);
        idle(60);
        // -2 on Y: two backward steps, B leads A
        cyc(0, -2, 1'b1, 1'b0);
        idle(40);
        // saturate X, then clear ovf while X keeps stepping
        repeat (20) cyc(127, 0, 1'b1, 1'b0);
        idle(5);
        cyc(0, 0, 1'b0, 1'b1);
        idle(40);
        // acc_x=+1 then -1 landing exactly on a tick edge
        do_reset();
        idle(1);
        while ((m_n + 1) % SD != 1) idle(1);
        cyc(1, 0, 1'b1, 1'b0);
        while ((m_n + 1) % SD != 0) idle(1);
        cyc(-1, 0, 1'b1, 1'b0);
        idle(40);
        // reset mid-motion discards pending motion
        cyc(50, 0, 1'b1, 1'b0);
        idle(100);
        do_reset();
        idle(60);
        // random traffic, including negative saturation and clear-vs-saturate collision
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0)
                cyc(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                    1'b1, $urandom_range(0, 15) == 0);
            else
                cyc(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        repeat (20) cyc(0, -128, 1'b1, 1'b0);
        cyc(0, -128, 1'b1, 1'b1);
        idle(20);
`ifdef TRAKBALL_RATE_SEL_EN
        rate_sel = 2'd2;
        m_div = SD >> 2;
        do_reset();
        idle(1);
        cyc(4, 0, 1'b1, 1'b0);
        idle(30);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
